operand_fetch: RTL and testbench

OPERAND_FETCH -- requirements
Module: operand_fetch

---
 rtl/operand_fetch.sv | 100 ++++++++++
 tb/tb_operand_fetch.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two registers through a shared-port register
// file and hands them to the ALU while arbitrating ALU writeback.
module operand_fetch #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [ADDR_W-1:0] req_src,
  output logic [ADDR_W-1:0] rf_dst_addr,
  output logic [ADDR_W-1:0] rf_src_addr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              rf_write,
  input  logic [DATA_W-1:0] rf_dst_data,
  input  logic [DATA_W-1:0] rf_src_data,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] op_dst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    CAP  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] src_q;

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    wb_ready  = 1'b0;
    unique case (state)
      IDLE: begin
        wb_ready  = 1'b1;
        req_ready = !wb_valid;
        if (req_valid && !wb_valid)
          state_nx = RD;
      end
      RD:  state_nx = CAP;
      CAP: state_nx = OUT;
      OUT: begin
        wb_ready = 1'b1;
        if (op_ready)
          state_nx = IDLE;
      end
    endcase
    // Nothing may be accepted while reset is held.
    if (rst) begin
      req_ready = 1'b0;
      wb_ready  = 1'b0;
    end
  end

  // The dst port is shared: writeback borrows it only outside RD/CAP.
  assign rf_write    = wb_valid && wb_ready;
  assign rf_dst_addr = rf_write ? wb_addr : dst_q;
  assign rf_wdata    = rf_write ? wb_data : '0;
  assign rf_src_addr = src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dst_q    <= '0;
      src_q    <= '0;
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      op_dst   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid && req_ready) begin
        dst_q <= req_dst;
        src_q <= req_src;
      end
      if (state == CAP) begin
        op_a     <= rf_dst_data;
        op_b     <= rf_src_data;
        op_dst   <= dst_q;
        op_valid <= 1'b1;
      end
      if (state == OUT && op_ready)
        op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: external register file plus a shadow
// register model that predicts operand values from accepted writebacks.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_dst;
  logic [3:0]  req_src;
  logic [3:0]  rf_dst_addr;
  logic [3:0]  rf_src_addr;
  logic [15:0] rf_wdata;
  logic        rf_write;
  logic [15:0] rf_dst_data;
  logic [15:0] rf_src_data;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  op_dst;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  int checks = 0;
  int errors = 0;

  logic [15:0] rf_mem [16];
  logic [15:0] model  [16];

  operand_fetch #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst(req_dst), .req_src(req_src),
    .rf_dst_addr(rf_dst_addr), .rf_src_addr(rf_src_addr),
    .rf_wdata(rf_wdata), .rf_write(rf_write),
    .rf_dst_data(rf_dst_data), .rf_src_data(rf_src_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_dst(op_dst),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_addr(wb_addr), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file with 1-cycle registered reads; cleared while rst is held.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
      rf_dst_data <= '0;
      rf_src_data <= '0;
    end else begin
      if (rf_write) rf_mem[rf_dst_addr] <= rf_wdata;
      rf_dst_data <= rf_mem[rf_dst_addr];
      rf_src_data <= rf_mem[rf_src_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = '0;
  endtask

  // One writeback presented in IDLE; it must take the port immediately.
  task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    req_valid = 1'b0;
    op_ready  = 1'b0;
    wb_valid  = 1'b1;
    wb_addr   = a;
    wb_data   = d;
    #1;
    check("idle_wb_write", rf_write, 1);
    check("idle_wb_addr", rf_dst_addr, a);
    check("idle_wb_data", rf_wdata, d);
    check("idle_wb_req_ready", req_ready, 0);
    model[a] = d;
  endtask

  // Full operation: accept, RD, CAP, then OUT for stall+1 cycles.
  task automatic run_op(input logic [3:0] d, input logic [3:0] s,
                        input int stall, input bit wb_early,
                        input bit hit_dst);
    logic [15:0] ea;
    logic [15:0] eb;
    logic [3:0]  wa;
    logic [15:0] wd;
    @(negedge clk);
    wb_valid  = 1'b0;
    op_ready  = 1'b0;
    req_valid = 1'b1;
    req_dst   = d;
    req_src   = s;
    #1;
    check("accept_req_ready", req_ready, 1);
    ea = model[d];
    eb = model[s];
    @(negedge clk);
    req_valid = 1'b0;
    req_dst   = 4'($urandom);
    req_src   = 4'($urandom);
    wa        = 4'($urandom);
    wd        = 16'($urandom);
    wb_valid  = wb_early;
    wb_addr   = wa;
    wb_data   = wd;
    #1;
    check("rd_wb_ready", wb_ready, 0);
    check("rd_rf_write", rf_write, 0);
    check("rd_dst_addr", rf_dst_addr, d);
    check("rd_src_addr", rf_src_addr, s);
    check("rd_op_valid", op_valid, 0);
    @(negedge clk);
    #1;
    check("cap_wb_ready", wb_ready, 0);
    check("cap_rf_write", rf_write, 0);
    check("cap_op_valid", op_valid, 0);
    check("cap_req_ready", req_ready, 0);
    for (int k = 0; k <= stall; k++) begin
      @(negedge clk);
      op_ready = (k == stall);
      if (!(k == 0 && wb_early)) begin
        wb_valid = hit_dst ? 1'b1 : 1'($urandom);
        wa       = hit_dst ? d : 4'($urandom);
        wd       = hit_dst ? 16'hFFFF : 16'($urandom);
        wb_addr  = wa;
        wb_data  = wd;
      end
      #1;
      check("out_op_valid", op_valid, 1);
      check("out_op_a", op_a, ea);
      check("out_op_b", op_b, eb);
      check("out_op_dst", op_dst, d);
      check("out_wb_ready", wb_ready, 1);
      check("out_rf_write", rf_write, wb_valid);
      if (wb_valid) model[wa] = wd;
    end
    @(negedge clk);
    wb_valid = 1'b0;
    op_ready = 1'b0;
    #1;
    check("done_op_valid", op_valid, 0);
    check("done_req_ready", req_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b1;
    req_dst   = 4'd9;
    req_src   = 4'd9;
    op_ready  = 1'b1;
    wb_valid  = 1'b1;
    wb_addr   = 4'd2;
    wb_data   = 16'h5555;
    clear_model();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_rf_write", rf_write, 0);
    check("rst_wb_ready", wb_ready, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_op_valid", op_valid, 0);
    check("rst_op_a", op_a, 0);
    check("rst_op_dst", op_dst, 0);
    check("rst_src_addr", rf_src_addr, 0);
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    wb_valid  = 1'b0;
    op_ready  = 1'b0;

    // Basic read of two preloaded registers.
    wb_write(4'd3, 16'h1234);
    wb_write(4'd7, 16'hBEEF);
    run_op(4'd3, 4'd7, 0, 1'b0, 1'b0);

    // Writeback and request collide in IDLE: writeback wins.
    @(negedge clk);
    wb_valid  = 1'b1;
    wb_addr   = 4'd5;
    wb_data   = 16'h00AA;
    req_valid = 1'b1;
    req_dst   = 4'd5;
    req_src   = 4'd3;
    #1;
    check("collide_rf_write", rf_write, 1);
    check("collide_req_ready", req_ready, 0);
    model[5] = 16'h00AA;
    run_op(4'd5, 4'd3, 0, 1'b0, 1'b0);

    // Stalled handoff with writes to the captured dst register.
    run_op(4'd3, 4'd7, 5, 1'b0, 1'b1);

    // Writeback held through RD/CAP lands in the first OUT cycle.
    run_op(4'd7, 4'd3, 1, 1'b1, 1'b0);
    run_op(4'd3, 4'd3, 0, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      int nw;
      nw = int'($urandom_range(0, 2));
      for (int w = 0; w < nw; w++)
        wb_write(4'($urandom), 16'($urandom));
      run_op(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), 1'b0);
    end

    // Reset while in CAP drops the operation.
    @(negedge clk);
    req_valid = 1'b1;
    req_dst   = 4'd7;
    req_src   = 4'd5;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    wb_valid  = 1'b1;
    req_valid = 1'b1;
    op_ready  = 1'b1;
    #1;
    check("cap_rst_op_valid", op_valid, 0);
    check("cap_rst_op_a", op_a, 0);
    check("cap_rst_op_b", op_b, 0);
    check("cap_rst_op_dst", op_dst, 0);
    check("cap_rst_rf_write", rf_write, 0);
    check("cap_rst_rf_wdata", rf_wdata, 0);
    check("cap_rst_wb_ready", wb_ready, 0);
    check("cap_rst_req_ready", req_ready, 0);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst       = 1'b0;
    wb_valid  = 1'b0;
    req_valid = 1'b0;
    op_ready  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      check("post_rst_op_valid", op_valid, 0);
    end

    wb_write(4'd3, 16'hC0DE);
    run_op(4'd3, 4'd7, 1, 1'b0, 1'b0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
